// File: rtl/fb_port_arbiter_if.sv
// Host write channel and SRAM port bundled for the frame-buffer arbiter.
// The slave modport is the arbiter. The master modport is the host plus the SRAM that surround it.
interface fb_port_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 19
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [2:0]    fifo_level;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, fifo_level, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, fifo_level, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Shares the single frame-buffer SRAM port between scan-out reads and host writes.
// Scan-out reads always win. Host writes wait in a small FIFO and drain in free cycles.
module fb_port_arbiter #(
  parameter int DW         = 8,
  parameter int AW         = 19,
  parameter int H_ACTIVE   = 640,
  parameter int H_TOTAL    = 800,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fb_port_arbiter_if.slave bus,
  input  logic          pix_pulse,
  input  logic [9:0]    col,
  input  logic [9:0]    row,
  input  logic          blank_only,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          frame_start
);

  localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [AW-1:0] LAST_PIX = AW'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [2:0]    DEPTH    = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t        state;
  logic [AW-1:0] scan_addr;
  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [2:0]    level;
  logic          active;
  logic          do_read;
  logic          do_write;
  logic          push;
  logic          resync;
  logic          rd_pend;

  assign active   = (col < H_ACT) && (row < V_ACT);
  assign do_read  = pix_pulse && active;
  assign do_write = !do_read && (level != 3'd0) && (!blank_only || !active);
  assign push     = bus.wr_valid && bus.wr_ready;
  assign resync   = pix_pulse && (col == H_LAST) && (row == V_LAST);

  // wr_ready looks only at the stored level, so a full FIFO never accepts, even while popping
  assign bus.wr_ready   = level < DEPTH;
  assign bus.fifo_level = level;
  assign bus.mem_en     = (state != IDLE);
  assign bus.mem_we     = (state == WRITE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= bus.wr_addr;
      fifo_data[tail] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      scan_addr     <= '0;
      head          <= '0;
      tail          <= '0;
      level         <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      rd_pend       <= 1'b0;
      pix_valid     <= 1'b0;
      pix_data      <= '0;
      frame_start   <= 1'b0;
    end else begin
      frame_start <= resync;
      // SRAM data arrives the cycle after a read, and it is registered one cycle later
      rd_pend     <= (state == READ);
      pix_valid   <= rd_pend;
      if (rd_pend) pix_data <= bus.mem_rdata;

      if (push) tail <= tail + 1'b1;
      if (do_write) head <= head + 1'b1;
      if (push && !do_write) level <= level + 3'd1;
      else if (!push && do_write) level <= level - 3'd1;

      if (do_read) begin
        state        <= READ;
        bus.mem_addr <= scan_addr;
        scan_addr    <= (scan_addr == LAST_PIX) ? '0 : scan_addr + 1'b1;
      end else if (do_write) begin
        state         <= WRITE;
        bus.mem_addr  <= fifo_addr[head];
        bus.mem_wdata <= fifo_data[head];
      end else begin
        state <= IDLE;
      end

      // The end-of-frame pulse is always in blanking, so it never coincides with a read
      if (resync) scan_addr <= '0;
    end
  end

endmodule
